// File: rtl/rst_seq_gen.sv
// Staged active-low reset sequencer: hold, wait for lock, staggered per-channel release, RUN.
// Optional WAIT_LOCK timeout/retry is compiled in when RSTSEQ_LOCK_TIMEOUT_EN is defined.
module rst_seq_gen #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 16,
    parameter int HOLD_CYC     = 100,
    parameter int STAGE_GAP    = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic            FPGA_SYSCLK,
    input  logic            RESET,
    input  logic            lock_in,
    input  logic            sw_rst_req,
    output logic            sw_rst_ack,
    output logic [N_CH-1:0] rst_out_n,
    output logic            seq_done,
    output logic            lock_lost,
    output logic            lock_timeout,
    output logic [1:0]      state_o
);
    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             pend_r;
    logic             req_q_r;

    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_s;
    logic [IDX_W-1:0] idx_s;
    logic [N_CH-1:0]  rst_s;
    logic             done_s;
    logic             ack_s;
    logic             lost_s;
    logic             tmo_s;
    logic             pend_s;
    logic             req_edge_s;

`ifndef RSTSEQ_LOCK_TIMEOUT_EN
    logic tmo_unused;
    assign tmo_unused = ^TMO_END;
`endif

    assign req_edge_s = sw_rst_req & ~req_q_r;

    // Next-state: a request edge beats lock loss, which beats the normal sequence.
    always_comb begin
        state_s = state_o;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rst_s   = rst_out_n;
        done_s  = seq_done;
        ack_s   = 1'b0;
        lost_s  = lock_lost;
        tmo_s   = lock_timeout;
        pend_s  = pend_r;
        if (req_edge_s) begin
            state_s = ST_HOLD;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            rst_s   = {N_CH{1'b0}};
            done_s  = 1'b0;
            lost_s  = 1'b0;
            tmo_s   = 1'b0;
            pend_s  = 1'b1;
        end else if (((state_o == ST_RELEASE) || (state_o == ST_RUN)) && !lock_in) begin
            state_s = ST_HOLD;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            rst_s   = {N_CH{1'b0}};
            done_s  = 1'b0;
            lost_s  = 1'b1;
        end else begin
            case (state_o)
                ST_HOLD: begin
                    rst_s  = {N_CH{1'b0}};
                    done_s = 1'b0;
                    if (cnt_r == HOLD_END) begin
                        state_s = ST_WAIT;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    rst_s  = {N_CH{1'b0}};
                    done_s = 1'b0;
                    if (lock_in) begin
                        state_s  = ST_RELEASE;
                        cnt_s    = {CNT_W{1'b0}};
                        idx_s    = {IDX_W{1'b0}};
                        rst_s[0] = 1'b1;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                    end else if (cnt_r == TMO_END) begin
                        state_s = ST_HOLD;
                        cnt_s   = {CNT_W{1'b0}};
                        tmo_s   = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
`else
                    end else begin
                        cnt_s = cnt_r;
                    end
                    tmo_s = 1'b0;
`endif
                end
                ST_RELEASE: begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_RUN;
                        cnt_s   = {CNT_W{1'b0}};
                        done_s  = 1'b1;
                        ack_s   = pend_r;
                        pend_s  = 1'b0;
                    end else if (cnt_r == GAP_END) begin
                        cnt_s        = {CNT_W{1'b0}};
                        idx_s        = idx_r + IDX_ONE;
                        rst_s[idx_s] = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    rst_s  = {N_CH{1'b1}};
                    done_s = 1'b1;
                end
                default: begin
                    state_s = ST_HOLD;
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    rst_s   = {N_CH{1'b0}};
                    done_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge FPGA_SYSCLK) begin
        if (RESET) begin
            state_o      <= ST_HOLD;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            rst_out_n    <= {N_CH{1'b0}};
            seq_done     <= 1'b0;
            sw_rst_ack   <= 1'b0;
            lock_lost    <= 1'b0;
            lock_timeout <= 1'b0;
            pend_r       <= 1'b0;
            req_q_r      <= 1'b0;
        end else begin
            state_o      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            rst_out_n    <= rst_s;
            seq_done     <= done_s;
            sw_rst_ack   <= ack_s;
            lock_lost    <= lost_s;
            lock_timeout <= tmo_s;
            pend_r       <= pend_s;
            req_q_r      <= sw_rst_req;
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: stimulus queues timed expected output snapshots,
// a negedge monitor compares on every scheduled cycle and flags any unscheduled output change.
module tb_rst_seq_gen;
    logic       FPGA_SYSCLK = 1'b0;
    logic       RESET;
    logic       lock_in;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic       lock_lost;
    logic       lock_timeout;
    logic [1:0] state_o;

    rst_seq_gen #(
        .N_CH(4), .CNT_W(16), .HOLD_CYC(100), .STAGE_GAP(16), .LOCK_TIMEOUT(50)
    ) dut (
        .FPGA_SYSCLK (FPGA_SYSCLK),
        .RESET       (RESET),
        .lock_in     (lock_in),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_ack  (sw_rst_ack),
        .rst_out_n   (rst_out_n),
        .seq_done    (seq_done),
        .lock_lost   (lock_lost),
        .lock_timeout(lock_timeout),
        .state_o     (state_o)
    );

    typedef struct {
        int         cyc;
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    initial forever #5 FPGA_SYSCLK = ~FPGA_SYSCLK;
    initial forever begin
        @(posedge FPGA_SYSCLK);
        cyc++;
    end

    // {state, rst_out_n, seq_done, sw_rst_ack, lock_lost, lock_timeout}
    function automatic logic [9:0] vec(input logic [1:0] st, input logic [3:0] r,
                                       input logic d, input logic a, input logic l, input logic t);
        return {st, r, d, a, l, t};
    endfunction

    task automatic expect_at(input int c, input logic [9:0] v, input string name);
        exp_t e;
        e.cyc = c; e.v = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge FPGA_SYSCLK);
    endtask

    task automatic exp_wait(input int c, input logic l, input logic t);
        expect_at(c, vec(2'd1, 4'h0, 1'b0, 1'b0, l, t), "enter_wait_lock");
    endtask

    task automatic exp_rel(input int r, input logic a, input logic l, input logic t);
        expect_at(r,      vec(2'd2, 4'h1, 1'b0, 1'b0, l, t), "release_ch0");
        expect_at(r + 16, vec(2'd2, 4'h3, 1'b0, 1'b0, l, t), "release_ch1");
        expect_at(r + 32, vec(2'd2, 4'h7, 1'b0, 1'b0, l, t), "release_ch2");
        expect_at(r + 48, vec(2'd2, 4'hF, 1'b0, 1'b0, l, t), "release_ch3");
        expect_at(r + 49, vec(2'd3, 4'hF, 1'b1, a, l, t), "run_entry");
        if (a) expect_at(r + 50, vec(2'd3, 4'hF, 1'b1, 1'b0, l, t), "ack_drop");
    endtask

    task automatic reset_pulse(input int n, output int base);
        int s;
        s = cyc;
        RESET = 1'b1;
        expect_at(s + 1, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_values");
        go_to(s + n);
        RESET = 1'b0;
        base = cyc;
    endtask

    // Monitor: scheduled compares, plus any output change nobody predicted.
    initial begin
        logic [9:0] cur;
        logic [9:0] prev;
        exp_t       e;
        prev = 10'd0;
        forever begin
            @(negedge FPGA_SYSCLK);
            cur = {state_o, rst_out_n, seq_done, sw_rst_ack, lock_lost, lock_timeout};
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    n_vec++; n_err++;
                    $display("FAIL %s: cycle %0d never sampled, required %b", e.name, e.cyc, e.v);
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (cur !== e.v) begin
                        n_err++;
                        $display("FAIL %s: cycle %0d got %b required %b", e.name, cyc, cur, e.v);
                    end
                end else if (cur !== prev) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_change: cycle %0d got %b was %b", cyc, cur, prev);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int b, r, q, t;
        exp_t e;
        RESET = 1'b1; lock_in = 1'b1; sw_rst_req = 1'b0;
        go_to(2);
        mon_en = 1'b1;
        expect_at(3, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_state");
        go_to(3);
        RESET = 1'b0;
        b = cyc;

        // nominal release from reset with lock already up
        exp_wait(b + 100, 1'b0, 1'b0);
        exp_rel(b + 101, 1'b0, 1'b0, 1'b0);
        go_to(b + 160);

`ifndef RSTSEQ_LOCK_TIMEOUT_EN
        // late lock shifts the whole release
        lock_in = 1'b0;
        reset_pulse(2, b);
        exp_wait(b + 100, 1'b0, 1'b0);
        exp_rel(b + 301, 1'b0, 1'b0, 1'b0);
        go_to(b + 300);
        lock_in = 1'b1;
        go_to(b + 360);
`else
        // lock timeout retries through HOLD; flag stays set through release
        lock_in = 1'b0;
        reset_pulse(2, b);
        exp_wait(b + 100, 1'b0, 1'b0);
        expect_at(b + 150, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1), "lock_timeout");
        exp_wait(b + 250, 1'b0, 1'b1);
        exp_rel(b + 261, 1'b0, 1'b0, 1'b1);
        go_to(b + 260);
        lock_in = 1'b1;
        go_to(b + 320);
`endif

        // software request held high: one restart, one ack
        q = cyc;
        sw_rst_req = 1'b1;
        expect_at(q + 1, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_accept");
        exp_wait(q + 101, 1'b0, 1'b0);
        exp_rel(q + 102, 1'b1, 1'b0, 1'b0);
        go_to(q + 500);
        sw_rst_req = 1'b0;
        go_to(q + 510);

        // lock loss after channel 1, then recovery with sticky lock_lost
        reset_pulse(2, b);
        exp_wait(b + 100, 1'b0, 1'b0);
        r = b + 101;
        expect_at(r,      vec(2'd2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0), "ll_ch0");
        expect_at(r + 16, vec(2'd2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0), "ll_ch1");
        expect_at(r + 17, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0), "lock_loss");
        exp_wait(r + 117, 1'b1, 1'b0);
        exp_rel(r + 118, 1'b0, 1'b1, 1'b0);
        go_to(r + 16);
        lock_in = 1'b0;
        go_to(r + 17);
        lock_in = 1'b1;

        // request clears lock_lost; second request in HOLD restarts the count
        go_to(r + 180);
        q = cyc;
        sw_rst_req = 1'b1;
        expect_at(q + 1, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_clears_lost");
        go_to(q + 1);
        sw_rst_req = 1'b0;
        go_to(q + 50);
        sw_rst_req = 1'b1;
        expect_at(q + 51, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_in_hold");
        go_to(q + 51);
        sw_rst_req = 1'b0;
        exp_wait(q + 151, 1'b0, 1'b0);
        exp_rel(q + 152, 1'b1, 1'b0, 1'b0);
        go_to(q + 210);

        // RESET in the middle of RELEASE
        reset_pulse(2, b);
        exp_wait(b + 100, 1'b0, 1'b0);
        expect_at(b + 101, vec(2'd2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0), "mid_ch0");
        expect_at(b + 117, vec(2'd2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0), "mid_ch1");
        expect_at(b + 120, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_mid_release");
        go_to(b + 119);
        RESET = 1'b1;
        go_to(b + 122);
        RESET = 1'b0;
        b = cyc;
        exp_wait(b + 100, 1'b0, 1'b0);
        exp_rel(b + 101, 1'b0, 1'b0, 1'b0);
        go_to(b + 160);

        // request edge and lock loss together: request wins
        t = cyc;
        lock_in = 1'b0;
        sw_rst_req = 1'b1;
        expect_at(t + 1, vec(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "req_beats_lockloss");
        go_to(t + 1);
        lock_in = 1'b1;
        sw_rst_req = 1'b0;
        exp_wait(t + 101, 1'b0, 1'b0);
        exp_rel(t + 102, 1'b1, 1'b0, 1'b0);
        go_to(t + 165);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++; n_err++;
            $display("FAIL %s: cycle %0d still pending, required %b", e.name, e.cyc, e.v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
